// File: rtl/snake_vga_pkg.sv
// Shared types and constants for the snake VGA block-memory read and write paths.
// The framebuffer is a 32x24 grid of 20x20 px blocks addressed as {row, col}.
package snake_vga_pkg;

    localparam int GRID_COLS = 32;
    localparam int GRID_ROWS = 24;
    localparam int BLOCK_PX  = 20;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 5;

    typedef enum logic {
        OP_WRITE_CELL,
        OP_CLEAR_ALL
    } fb_op_t;

    typedef struct packed {
        fb_op_t     op;
        logic [4:0] x;
        logic [4:0] y;
        logic [4:0] data;
    } fb_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_CLEAR
    } fb_state_t;

    // Row lives in the upper five address bits so the read side can scan rows linearly.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] y, input logic [4:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/snake_fb_writer_if.sv
// Command channel from game logic plus the block-memory write bus it produces.
// The master modport is the game-logic/memory side, the slave modport is the writer.
interface snake_fb_writer_if;
    import snake_vga_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    fb_op_t            cmd_op;
    logic [4:0]        cmd_x;
    logic [4:0]        cmd_y;
    logic [4:0]        cmd_data;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_data,
        input  cmd_ready, we, waddr, wdata
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_data,
        output cmd_ready, we, waddr, wdata
    );

endinterface

// File: rtl/fb_cmd_fifo.sv
// Registered (non fall-through) command FIFO; a push at edge N is visible at the head
// in cycle N+1. DEPTH must be a power of two, at least 2.
module fb_cmd_fifo
    import snake_vga_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  fb_cmd_t din,
    input  logic    pop,
    output fb_cmd_t dout,
    output logic    full,
    output logic    empty
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fb_cmd_fifo DEPTH must be a power of two and at least 2");
    end

    fb_cmd_t     mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/snake_fb_writer.sv
// Turns queued game-logic commands into block-memory write strobes: single-cell writes
// and a full-screen clear sweep. Define VBLANK_GATE_EN to restrict writes to vertical blank.
module snake_fb_writer
    import snake_vga_pkg::*;
#(
    parameter int GRID_COLS  = snake_vga_pkg::GRID_COLS,
    parameter int GRID_ROWS  = snake_vga_pkg::GRID_ROWS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vblank,
    snake_fb_writer_if.slave bus,
    output logic             busy,
    output logic             clear_done,
    output logic             cmd_err
);

    localparam logic [4:0] COL_LAST = 5'(GRID_COLS - 1);
    localparam logic [4:0] ROW_LIM  = 5'(GRID_ROWS);

    fb_state_t         state;
    fb_state_t         next_state;

    fb_cmd_t           cmd_in;
    fb_cmd_t           head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              gate;

    logic [4:0]        sx;
    logic [4:0]        sy;
    logic [4:0]        clear_val;
    logic [4:0]        sx_n;
    logic [4:0]        sy_n;
    logic [4:0]        clear_val_n;

    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              done_q;
    logic              err_q;
    logic              we_n;
    logic [ADDR_W-1:0] waddr_n;
    logic [DATA_W-1:0] wdata_n;
    logic              done_n;
    logic              err_n;

`ifdef VBLANK_GATE_EN
    assign gate = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign gate          = 1'b1;
`endif

    assign cmd_in.op   = bus.cmd_op;
    assign cmd_in.x    = bus.cmd_x;
    assign cmd_in.y    = bus.cmd_y;
    assign cmd_in.data = bus.cmd_data;

    assign bus.cmd_ready = !fifo_full;
    assign push          = bus.cmd_valid && !fifo_full;

    fb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.we     = we_q;
    assign bus.waddr  = waddr_q;
    assign bus.wdata  = wdata_q;
    assign clear_done = done_q;
    assign cmd_err    = err_q;
    assign busy       = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            sx        <= '0;
            sy        <= '0;
            clear_val <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= next_state;
            sx        <= sx_n;
            sy        <= sy_n;
            clear_val <= clear_val_n;
            we_q      <= we_n;
            waddr_q   <= waddr_n;
            wdata_q   <= wdata_n;
            done_q    <= done_n;
            err_q     <= err_n;
        end
    end

    // Write outputs are computed one cycle early so the popped command's strobe
    // appears in the WRITE cycle itself; sy reaching ROW_LIM marks the sweep as finished.
    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        sx_n        = sx;
        sy_n        = sy;
        clear_val_n = clear_val;
        we_n        = 1'b0;
        waddr_n     = waddr_q;
        wdata_n     = wdata_q;
        done_n      = 1'b0;
        err_n       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty && gate) begin
                    pop = 1'b1;
                    if (head.op == OP_CLEAR_ALL) begin
                        clear_val_n = head.data;
                        sx_n        = '0;
                        sy_n        = '0;
                        next_state  = ST_CLEAR;
                    end else begin
                        next_state = ST_WRITE;
                        if (head.y < ROW_LIM) begin
                            we_n    = 1'b1;
                            waddr_n = cell_addr(head.y, head.x);
                            wdata_n = head.data;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
            end

            ST_WRITE: begin
                next_state = ST_IDLE;
            end

            ST_CLEAR: begin
                if (sy == ROW_LIM) begin
                    done_n     = 1'b1;
                    next_state = ST_IDLE;
                end else if (gate) begin
                    we_n    = 1'b1;
                    waddr_n = cell_addr(sy, sx);
                    wdata_n = clear_val;
                    if (sx == COL_LAST) begin
                        sx_n = '0;
                        sy_n = sy + 5'd1;
                    end else begin
                        sx_n = sx + 5'd1;
                    end
                end
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_snake_fb_writer.sv
// Self-checking bench for snake_fb_writer: table-driven single-cell writes plus
// hand-written clear, queue/backpressure, mid-clear reset and (optionally) vblank sequences.
module tb_snake_fb_writer;
    import snake_vga_pkg::*;

    logic clk;
    logic reset;
    logic vblank;
    logic busy;
    logic clear_done;
    logic cmd_err;

    snake_fb_writer_if bus ();

    snake_fb_writer dut (
        .clk        (clk),
        .reset      (reset),
        .vblank     (vblank),
        .bus        (bus),
        .busy       (busy),
        .clear_done (clear_done),
        .cmd_err    (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        fb_op_t     op;
        logic [4:0] x;
        logic [4:0] y;
        logic [4:0] data;
        logic       exp_we;
        logic [9:0] exp_waddr;
        logic [4:0] exp_wdata;
        logic       exp_err;
    } vec_t;

    vec_t       vec [6];
    int         checks;
    int         errors;

    int         cycle;
    logic [9:0] wr_addr_q [$];
    logic [4:0] wr_data_q [$];
    int         wr_cycle_q [$];
    int         done_cnt;
    int         done_cycle;
    logic       done_busy;
    int         base_wr;
    int         base_done;

    // Sole writer of the write/done logs; sequences only read them against a baseline.
    initial begin
        cycle      = 0;
        done_cnt   = 0;
        done_cycle = -1;
        done_busy  = 1'b1;
    end

    always @(negedge clk) begin
        cycle = cycle + 1;
        if (!reset) begin
            if (bus.we) begin
                wr_addr_q.push_back(bus.waddr);
                wr_data_q.push_back(bus.wdata);
                wr_cycle_q.push_back(cycle);
            end
            if (clear_done) begin
                done_cnt   = done_cnt + 1;
                done_cycle = cycle;
                done_busy  = busy;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Waits for cmd_ready, offers one command for exactly one edge, returns #1 after it.
    task automatic applyStimulus(input fb_op_t op, input logic [4:0] x, input logic [4:0] y,
                                 input logic [4:0] data);
        int n = 0;
        while (!bus.cmd_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("push_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_data  = data;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic waitIdle(input int limit, input string name);
        int n = 0;
        while (busy && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({name, "_idle"}, busy, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic markLog();
        base_wr   = wr_addr_q.size();
        base_done = done_cnt;
    endtask

    initial begin
        int         n;
        int         bad;
        int         last_cycle;
        logic [9:0] exp_addr [4];
        logic [4:0] exp_data [4];

        checks        = 0;
        errors        = 0;
        base_wr       = 0;
        base_done     = 0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_WRITE_CELL;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_data  = '0;
`ifdef VBLANK_GATE_EN
        vblank = 1'b1;
`else
        vblank = 1'b0;
`endif
        $display("[TB] grid %0dx%0d blocks of %0d px", GRID_COLS, GRID_ROWS, BLOCK_PX);

        vec[0] = '{OP_WRITE_CELL, 5'd5,  5'd3,  5'd7,  1'b1, 10'h065, 5'd7,  1'b0};
        vec[1] = '{OP_WRITE_CELL, 5'd31, 5'd23, 5'd31, 1'b1, 10'h2FF, 5'd31, 1'b0};
        vec[2] = '{OP_WRITE_CELL, 5'd0,  5'd0,  5'd1,  1'b1, 10'h000, 5'd1,  1'b0};
        vec[3] = '{OP_WRITE_CELL, 5'd0,  5'd24, 5'd9,  1'b0, 10'h000, 5'd1,  1'b1};
        vec[4] = '{OP_WRITE_CELL, 5'd17, 5'd12, 5'd20, 1'b1, 10'h191, 5'd20, 1'b0};
        vec[5] = '{OP_WRITE_CELL, 5'd31, 5'd31, 5'd3,  1'b0, 10'h191, 5'd20, 1'b1};

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_we", bus.we, 0);
        checkOutput("rst_waddr", bus.waddr, 0);
        checkOutput("rst_wdata", bus.wdata, 0);
        checkOutput("rst_clear_done", clear_done, 0);
        checkOutput("rst_cmd_err", cmd_err, 0);
        checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
        checkOutput("rst_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single-cell writes: accept at N, strobe only in N+2
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vec[i].op, vec[i].x, vec[i].y, vec[i].data);
            checkOutput($sformatf("v%0d_we_n1", i), bus.we, 0);
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d_we", i), bus.we, vec[i].exp_we);
            checkOutput($sformatf("v%0d_waddr", i), bus.waddr, vec[i].exp_waddr);
            checkOutput($sformatf("v%0d_wdata", i), bus.wdata, vec[i].exp_wdata);
            checkOutput($sformatf("v%0d_err", i), cmd_err, vec[i].exp_err);
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d_we_n3", i), bus.we, 0);
            checkOutput($sformatf("v%0d_err_n3", i), cmd_err, 0);
            checkOutput($sformatf("v%0d_busy_n3", i), busy, 0);
        end

        // Full clear sweep with a nonzero fill value
        markLog();
        applyStimulus(OP_CLEAR_ALL, 5'd0, 5'd0, 5'd5);
        waitIdle(2000, "clear");
        n = wr_addr_q.size() - base_wr;
        checkOutput("clear_count", n, 768);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (wr_addr_q[base_wr + i] !== 10'(i) || wr_data_q[base_wr + i] !== 5'd5) bad++;
        end
        checkOutput("clear_order", bad, 0);
        last_cycle = (n > 0) ? wr_cycle_q[base_wr + n - 1] : -10;
        checkOutput("clear_done_count", done_cnt - base_done, 1);
        checkOutput("clear_done_timing", done_cycle, last_cycle + 1);
        checkOutput("clear_done_busy", done_busy, 0);

        // Writes queued behind a clear: backpressure, then in-order after the sweep
        exp_addr = '{10'h001, 10'h022, 10'h056, 10'h2FF};
        exp_data = '{5'd3, 5'd4, 5'd6, 5'd8};
        markLog();
        applyStimulus(OP_CLEAR_ALL, 5'd0, 5'd0, 5'd0);
        applyStimulus(OP_WRITE_CELL, 5'd1, 5'd0, 5'd3);
        applyStimulus(OP_WRITE_CELL, 5'd2, 5'd1, 5'd4);
        applyStimulus(OP_WRITE_CELL, 5'd22, 5'd2, 5'd6);
        applyStimulus(OP_WRITE_CELL, 5'd31, 5'd23, 5'd8);
        checkOutput("queue_ready_full", bus.cmd_ready, 0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        checkOutput("queue_ready_held", bus.cmd_ready, 0);
        checkOutput("queue_busy", busy, 1);
        waitIdle(3000, "queue");
        n = wr_addr_q.size() - base_wr;
        checkOutput("queue_count", n, 772);
        bad = 0;
        for (int i = 0; i < 768 && i < n; i++) begin
            if (wr_addr_q[base_wr + i] !== 10'(i) || wr_data_q[base_wr + i] !== 5'd0) bad++;
        end
        checkOutput("queue_clear_order", bad, 0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (768 + i >= n) bad++;
            else if (wr_addr_q[base_wr + 768 + i] !== exp_addr[i] ||
                     wr_data_q[base_wr + 768 + i] !== exp_data[i]) bad++;
        end
        checkOutput("queue_tail_order", bad, 0);
        checkOutput("queue_done_count", done_cnt - base_done, 1);
        last_cycle = (n > 768) ? wr_cycle_q[base_wr + 768] : -10;
        checkOutput("queue_first_write_cycle", last_cycle, done_cycle + 1);

        // Reset in the middle of a sweep, with a write still queued
        markLog();
        applyStimulus(OP_CLEAR_ALL, 5'd0, 5'd0, 5'd9);
        applyStimulus(OP_WRITE_CELL, 5'd4, 5'd4, 5'd1);
        n = 0;
        while ((wr_addr_q.size() - base_wr) < 300 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("midclear_reached", (wr_addr_q.size() - base_wr) >= 300, 1);
        checkOutput("midclear_we_before", bus.we, 1);
        reset = 1'b1;
        #1;
        checkOutput("midclear_we_async", bus.we, 0);
        checkOutput("midclear_ready_async", bus.cmd_ready, 1);
        checkOutput("midclear_busy_async", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n = wr_addr_q.size();
        repeat (20) begin
            @(posedge clk); #1;
        end
        checkOutput("midclear_no_writes", wr_addr_q.size() - n, 0);
        checkOutput("midclear_no_done", done_cnt - base_done, 0);
        checkOutput("midclear_ready", bus.cmd_ready, 1);
        checkOutput("midclear_busy", busy, 0);

`ifdef VBLANK_GATE_EN
        // Gate closed: nothing may be written until vblank rises
        vblank = 1'b0;
        markLog();
        applyStimulus(OP_WRITE_CELL, 5'd3, 5'd2, 5'd7);
        repeat (6) begin
            @(posedge clk); #1;
        end
        checkOutput("gate_no_write", wr_addr_q.size() - base_wr, 0);
        vblank = 1'b1;
        @(posedge clk); #1;
        checkOutput("gate_we", bus.we, 1);
        checkOutput("gate_waddr", bus.waddr, 10'h043);
        waitIdle(50, "gate_write");

        markLog();
        applyStimulus(OP_CLEAR_ALL, 5'd0, 5'd0, 5'd2);
        n = 0;
        while ((wr_addr_q.size() - base_wr) < 100 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        vblank = 1'b0;
        @(posedge clk); #1;
        n = wr_addr_q.size();
        repeat (10) begin
            @(posedge clk); #1;
        end
        checkOutput("gate_clear_paused", wr_addr_q.size() - n, 0);
        vblank = 1'b1;
        waitIdle(2000, "gate_clear");
        n = wr_addr_q.size() - base_wr;
        checkOutput("gate_clear_count", n, 768);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (wr_addr_q[base_wr + i] !== 10'(i)) bad++;
        end
        checkOutput("gate_clear_order", bad, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
